// File: rtl/uart_cmd_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command with an inter-byte timeout,
// and returns one response byte per request. Optional macro OVERRUN_DETECT_EN adds a sticky overrun flag.
module uart_cmd_assembler #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
`ifdef OVERRUN_DETECT_EN
  output logic        overrun,
`endif
  output logic        resp_sent
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, WAIT_LOW} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t rx_st, rx_nxt;
  tx_state_t tx_st, tx_nxt;

  logic [CW-1:0] cnt;
  logic [7:0]    high_byte;
  logic          take_hi;
  logic          take_lo;

  // rx path: a byte arriving on the timeout cycle is accepted rather than dropped
  always_comb begin
    rx_nxt     = rx_st;
    clr_rx_rdy = 1'b0;
    frame_err  = 1'b0;
    take_hi    = 1'b0;
    take_lo    = 1'b0;
    if (!rst) begin
      case (rx_st)
        IDLE: begin
          if (rx_rdy) begin
            clr_rx_rdy = 1'b1;
            take_hi    = 1'b1;
            rx_nxt     = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (rx_rdy) begin
            clr_rx_rdy = 1'b1;
            take_lo    = 1'b1;
            rx_nxt     = IDLE;
          end else if (cnt == LIMIT) begin
            frame_err = 1'b1;
            rx_nxt    = IDLE;
          end
        end
        default: rx_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= IDLE;
      cnt       <= '0;
      high_byte <= 8'h00;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
    end else begin
      rx_st <= rx_nxt;
      if (take_hi) begin
        high_byte <= rx_data;
        cnt       <= '0;
      end else if (frame_err) begin
        high_byte <= 8'h00;
        cnt       <= '0;
      end else if (rx_st == WAIT_LOW && !take_lo) begin
        cnt <= cnt + 1'b1;
      end
      if (take_lo) begin
        cmd     <= {high_byte, rx_data};
        cmd_rdy <= 1'b1;
      end else if (take_hi || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

`ifdef OVERRUN_DETECT_EN
  // cmd_rdy drops on every high byte, so remember whether the previous command
  // was still unconsumed when this frame started.
  logic stale;

  always_ff @(posedge clk) begin
    if (rst) begin
      stale   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (take_hi)
        stale <= cmd_rdy && !clr_cmd_rdy;
      else if (clr_cmd_rdy)
        stale <= 1'b0;
      if (take_lo && stale && !clr_cmd_rdy)
        overrun <= 1'b1;
    end
  end
`endif

  always_comb begin
    tx_nxt = tx_st;
    trmt   = 1'b0;
    if (!rst) begin
      case (tx_st)
        TX_IDLE: begin
          if (send_resp) begin
            trmt   = 1'b1;
            tx_nxt = TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) tx_nxt = TX_IDLE;
        end
        default: tx_nxt = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st     <= TX_IDLE;
      tx_data   <= 8'h00;
      resp_sent <= 1'b0;
    end else begin
      tx_st <= tx_nxt;
      if (trmt) begin
        tx_data   <= resp;
        resp_sent <= 1'b0;
      end else if (tx_st == TX_BUSY && tx_done) begin
        resp_sent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench: short-timeout instance for framing/tx/reset, default-timeout instance for slow byte spacing.
module tb_uart_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data, rx_data_l;
  logic        rx_rdy, rx_rdy_l;
  logic        clr_rx_rdy, clr_rx_rdy_l;
  logic [15:0] cmd, cmd_l;
  logic        cmd_rdy, cmd_rdy_l;
  logic        clr_cmd_rdy;
  logic        frame_err, frame_err_l;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data, tx_data_l;
  logic        trmt, trmt_l;
  logic        tx_done;
  logic        resp_sent, resp_sent_l;
`ifdef OVERRUN_DETECT_EN
  logic        overrun, overrun_l;
`endif

  int nvec = 0;
  int nerr = 0;
  int fe_cnt = 0, fe_cnt_l = 0, clr_cnt_l = 0;
  int base_a, base_b;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)    fe_cnt++;
    if (frame_err_l)  fe_cnt_l++;
    if (clr_rx_rdy_l) clr_cnt_l++;
  end

  uart_cmd_assembler #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .resp(resp), .send_resp(send_resp), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
`ifdef OVERRUN_DETECT_EN
    .overrun(overrun),
`endif
    .resp_sent(resp_sent)
  );

  uart_cmd_assembler dut_long (
    .clk(clk), .rst(rst), .rx_data(rx_data_l), .rx_rdy(rx_rdy_l), .clr_rx_rdy(clr_rx_rdy_l),
    .cmd(cmd_l), .cmd_rdy(cmd_rdy_l), .clr_cmd_rdy(1'b0), .frame_err(frame_err_l),
    .resp(8'h00), .send_resp(1'b0), .tx_data(tx_data_l), .trmt(trmt_l), .tx_done(1'b0),
`ifdef OVERRUN_DETECT_EN
    .overrun(overrun_l),
`endif
    .resp_sent(resp_sent_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h77; rx_rdy = 1'b1; rx_data_l = 8'h00; rx_rdy_l = 1'b0;
    clr_cmd_rdy = 1'b0; resp = 8'h99; send_resp = 1'b1; tx_done = 1'b0;

    // reset state, with requests active during reset
    tick(); tick();
    chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
    chk("rst_trmt", 32'(trmt), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("rst_resp_sent", 32'(resp_sent), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    rst = 1'b0; rx_rdy = 1'b0; send_resp = 1'b0;
    tick();

    // A5 then 3C, 20 cycles apart, default timeout
    base_a = clr_cnt_l; base_b = fe_cnt_l;
    rx_data_l = 8'hA5; rx_rdy_l = 1'b1;
    #1 chk("hi_clr_pulse", 32'(clr_rx_rdy_l), 32'h1);
    tick(); rx_rdy_l = 1'b0;
    repeat (19) tick();
    chk("mid_cmd_rdy", 32'(cmd_rdy_l), 32'h0);
    rx_data_l = 8'h3C; rx_rdy_l = 1'b1;
    tick(); rx_rdy_l = 1'b0;
    chk("slow_cmd", 32'(cmd_l), 32'hA53C);
    chk("slow_cmd_rdy", 32'(cmd_rdy_l), 32'h1);
    chk("slow_clr_count", 32'(clr_cnt_l - base_a), 32'd2);
    chk("slow_no_frame_err", 32'(fe_cnt_l - base_b), 32'd0);

    // inter-byte timeout with TIMEOUT_CYC=16
    send_byte(8'h12);
    base_b = fe_cnt;
    repeat (14) tick();
    chk("to_early", 32'(frame_err), 32'h0);
    tick();
    chk("to_pulse", 32'(frame_err), 32'h1);
    tick();
    chk("to_after", 32'(frame_err), 32'h0);
    chk("to_count", 32'(fe_cnt - base_b), 32'd1);
    chk("to_cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("to_cmd_kept", 32'(cmd), 32'h0);
    send_byte(8'h34); send_byte(8'h56);
    chk("resync_cmd", 32'(cmd), 32'h3456);
    chk("resync_rdy", 32'(cmd_rdy), 32'h1);

    // consumer acknowledge, then ack coinciding with assembly
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("ack_rdy", 32'(cmd_rdy), 32'h0);
    chk("ack_cmd_hold", 32'(cmd), 32'h3456);
    send_byte(8'h78);
    rx_data = 8'h9A; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick(); rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk("set_wins_rdy", 32'(cmd_rdy), 32'h1);
    chk("set_wins_cmd", 32'(cmd), 32'h789A);

`ifdef OVERRUN_DETECT_EN
    chk("ovr_idle", 32'(overrun), 32'h0);
    send_byte(8'hBC); send_byte(8'hDE);
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_cmd", 32'(cmd), 32'hBCDE);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    repeat (3) tick();
    chk("ovr_sticky", 32'(overrun), 32'h1);
`endif

    // response path
    resp = 8'hA5; send_resp = 1'b1;
    #1 chk("tx_trmt", 32'(trmt), 32'h1);
    tick(); send_resp = 1'b0;
    chk("tx_data", 32'(tx_data), 32'hA5);
    chk("tx_trmt_one", 32'(trmt), 32'h0);
    resp = 8'h00; send_resp = 1'b1;
    #1 chk("tx_busy_no_trmt", 32'(trmt), 32'h0);
    tick(); send_resp = 1'b0;
    chk("tx_busy_data", 32'(tx_data), 32'hA5);
    chk("tx_busy_sent", 32'(resp_sent), 32'h0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("tx_sent", 32'(resp_sent), 32'h1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("tx_idle_done", 32'(resp_sent), 32'h1);
    resp = 8'h5A; send_resp = 1'b1;
    #1 chk("tx2_trmt", 32'(trmt), 32'h1);
    tick(); send_resp = 1'b0;
    chk("tx2_sent_clr", 32'(resp_sent), 32'h0);
    chk("tx2_data", 32'(tx_data), 32'h5A);
    tx_done = 1'b1; tick(); tx_done = 1'b0;

    // low byte arriving on the timeout cycle is accepted
    send_byte(8'h11);
    repeat (15) tick();
    rx_data = 8'h22; rx_rdy = 1'b1;
    #1 chk("edge_no_fe", 32'(frame_err), 32'h0);
    chk("edge_clr", 32'(clr_rx_rdy), 32'h1);
    tick(); rx_rdy = 1'b0;
    chk("edge_cmd", 32'(cmd), 32'h1122);

    // reset mid-frame
    send_byte(8'hFF);
    rst = 1'b1; rx_data = 8'h33; rx_rdy = 1'b1; send_resp = 1'b1;
    #1 chk("mrst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
    chk("mrst_trmt", 32'(trmt), 32'h0);
    tick();
    chk("mrst_frame_err", 32'(frame_err), 32'h0);
    chk("mrst_cmd", 32'(cmd), 32'h0);
    chk("mrst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("mrst_resp_sent", 32'(resp_sent), 32'h0);
    chk("mrst_tx_data", 32'(tx_data), 32'h0);
`ifdef OVERRUN_DETECT_EN
    chk("mrst_overrun", 32'(overrun), 32'h0);
`endif
    rst = 1'b0; rx_rdy = 1'b0; send_resp = 1'b0;
    tick();
    send_byte(8'h01); send_byte(8'h02);
    chk("post_rst_cmd", 32'(cmd), 32'h0102);
    chk("post_rst_rdy", 32'(cmd_rdy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
